pio_ep_regbank: RTL and testbench
=================================

// Module: pio_ep_regbank
// PURPOSE
//  Parametrised PCIe PIO BAR0 register bank for NUM_CH independent IPNUMA tunnels.
//  Sits between the PIO RX/TX engines and the Ethernet datapath.
//  Holds per-channel local/dest IPv4 and MAC, an enable bit and saturating TX/RX packet counters.
//  Provides a registered read path with a valid strobe and a write path with a busy handshake.
// PARAMETERS
//  NUM_CH  2   number of channels (1..32)
//  ADDR_W  14  dword address width of rd_addr/wr_addr
//  CNT_W   32  packet counter width (<=32)
// PORTS
//  clk              in   1            clock
//  rst_n            in   1            reset, synchronous, active-low
//  rd_req           in   1            read strobe, rd_addr valid this cycle
//  rd_addr          in   ADDR_W       read dword address
//  rd_be            in   4            read byte enables (ignored; full dword returned)
//  rd_data          out  32           read data, valid with rd_valid
//  rd_valid         out  1            read data strobe
//  wr_en            in   1            write strobe; ignored while wr_busy=1
//  wr_addr          in   ADDR_W       write dword address
//  wr_be            in   4            byte enables: be[0]->data[31:24] ... be[3]->data[7:0]
//  wr_data          in   32           write data
//  wr_busy          out  1            write stage occupied
//  tx_pkt_inc       in   NUM_CH       per-channel TX packet pulse
//  rx_pkt_inc       in   NUM_CH       per-channel RX packet pulse
//  ch_enable        out  NUM_CH       per-channel enable
//  ch_if_v4addr     out  NUM_CH*32    local IPv4, channel i at [32i+:32]
//  ch_if_macaddr    out  NUM_CH*48    local MAC
//  ch_dest_v4addr   out  NUM_CH*32    destination IPv4
//  ch_dest_macaddr  out  NUM_CH*48    destination MAC
// BEHAVIOUR
//  Region select is addr[13:12]:
//   - 00 and 10 read 0 and ignore writes.
//   - 01 holds registers: channel = addr[8:4], offset = addr[3:0].
//   - 11 is the ROM window (see CONFIGURATION).
//  Offsets:
//   - 0 if_v4; 2 if_mac[47:16]; 3 {if_mac[15:0],16'h0}; 4 dest_v4.
//   - 6 dest_mac[47:16]; 7 {dest_mac[15:0],16'h0}.
//   - 8 ctrl: bit0 enable, bit1 counter-clear (write-1, self-clearing, reads 0).
//   - 9 tx_cnt; A rx_cnt; both clear-on-read.
//   - F ID = 32'h5049_0000|NUM_CH, read-only.
//   - Other offsets, and channel>=NUM_CH: read 0, writes dropped.
//  Read latency is exactly 1 cycle: rd_valid=1 and rd_data are set the cycle after rd_req.
//   - Without rd_req, rd_valid=0 and rd_data holds its previous value.
//   - Back-to-back reads are accepted every cycle.
//  Write is 2-stage:
//   - An accepted wr_en is captured into a staging register; wr_busy=1 the next cycle.
//   - Target bytes update at the end of that busy cycle; wr_busy drops after.
//   - Max one write per 2 cycles.
//   - wr_en while busy: ignored, no side effect.
//  Read/write ordering:
//   - A read in the busy cycle returns the old value.
//   - A read one cycle later returns the new value.
//  Counters:
//   - Increment on inc pulse only when ch_enable[i]=1.
//   - Saturate at all-ones, no wrap.
//   - Clear-on-read takes effect in the rd_req cycle; rd_data returns the pre-clear value.
//   - Inc in the same cycle as clear or ctrl bit1 leaves the counter at 1.
//   - TX and RX are independent.
//  Reset, per channel i:
//   - if_v4 = {10,0,21,199+i} (last octet mod 256); if_mac = 48'h003776_000001+i.
//   - dest_v4 = {10,0,21,255}; dest_mac = all ones.
//   - enable=1; counters=0.
//   - rd_data=0, rd_valid=0, wr_busy=0; staging write discarded.
//  Reset mid-write: the write is lost, registers take reset values.
// CONFIGURATION
//  PIO_REGBANK_ROM_EN defined:
//   - Instantiates biosrom (addr=rd_addr[11:0]); region 11 returns ROM data with the same 1-cycle latency.
//   - Region 11 writes are ignored.
//  Undefined: region 11 reads 0; no ROM instantiated.
// STRUCTURE
//  Package pio_regbank_pkg holds:
//   - Region codes and offset localparams (OFF_IF_V4 .. OFF_ID).
//   - ID constant 16'h5049.
//   - Reset-default constants.
//  Sub-module pio_regbank_ch: one channel's registers and counters plus byte-lane write logic.
//   - Generated NUM_CH times.
//   - The top holds decode, read mux/pipeline and the write staging register.
// TESTING
//  1. Reset, NUM_CH=2: read 0x1000 -> 0x0A0015C7; read 0x1010 -> 0x0A0015C8; read 0x100F -> 0x50490002.
//  2. Write 0x1004 data 0xC0A80001 be=4'b0011 -> reads 0xC0A815FF.
//     Second wr_en in the busy cycle -> dropped.
//  3. Five tx_pkt_inc[0] pulses:
//     - Read 0x1009 -> 5, then 0.
//     - Read coincident with an inc -> returns N, next read 1.
//  4. CNT_W=4, 20 rx pulses -> rx_cnt reads 0xF.
//     Write ctrl 0x1008 = 0 then pulse -> count unchanged.
//  5. Read 0x1020 (channel 2, NUM_CH=2) -> 0; write there -> no output changes.
//  6. With PIO_REGBANK_ROM_EN: read 0x3000 -> ROM word 0, rd_valid 1 cycle later.
//     Without the macro: read 0x3000 -> 0.

Source files
------------

// File: rtl/pio_regbank_pkg.sv
// Shared constants, write payload type and helpers for the PIO BAR0 register bank.
package pio_regbank_pkg;

   localparam logic [1:0] REG_ZERO_LO = 2'b00;
   localparam logic [1:0] REG_CH      = 2'b01;
   localparam logic [1:0] REG_ZERO_HI = 2'b10;
   localparam logic [1:0] REG_ROM     = 2'b11;

   localparam logic [3:0] OFF_IF_V4       = 4'h0;
   localparam logic [3:0] OFF_IF_MAC_HI   = 4'h2;
   localparam logic [3:0] OFF_IF_MAC_LO   = 4'h3;
   localparam logic [3:0] OFF_DEST_V4     = 4'h4;
   localparam logic [3:0] OFF_DEST_MAC_HI = 4'h6;
   localparam logic [3:0] OFF_DEST_MAC_LO = 4'h7;
   localparam logic [3:0] OFF_CTRL        = 4'h8;
   localparam logic [3:0] OFF_TX_CNT      = 4'h9;
   localparam logic [3:0] OFF_RX_CNT      = 4'hA;
   localparam logic [3:0] OFF_ID          = 4'hF;

   localparam logic [15:0] ID_HI = 16'h5049;

   localparam logic [23:0] RST_IF_V4_HI = 24'h0A0015;
   localparam logic [7:0]  RST_IF_V4_LO = 8'd199;
   localparam logic [47:0] RST_IF_MAC   = 48'h003776_000001;
   localparam logic [31:0] RST_DEST_V4  = 32'h0A0015FF;
   localparam logic [47:0] RST_DEST_MAC = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic [3:0]  off;
      logic [3:0]  be;
      logic [31:0] data;
   } ch_wr_t;

   // be[0] owns the most significant byte, be[3] the least
   function automatic logic [31:0] merge_be(input logic [31:0] cur,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[31-8*b -: 8] = wdata[31-8*b -: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] rst_if_v4(input int unsigned ch);
      return {RST_IF_V4_HI, RST_IF_V4_LO + 8'(ch)};
   endfunction

   function automatic logic [47:0] rst_if_mac(input int unsigned ch);
      return RST_IF_MAC + 48'(ch);
   endfunction

endpackage

// File: rtl/pio_regbank_ch.sv
// One tunnel channel: address/MAC/enable registers, byte-lane writes, saturating counters.
module pio_regbank_ch
   import pio_regbank_pkg::*;
#(
   parameter int unsigned CH_IDX = 0,
   parameter int unsigned CNT_W  = 32
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_apply,
   input  ch_wr_t      wr,
   input  logic [3:0]  rd_off,
   input  logic        rd_sel,
   input  logic        tx_inc,
   input  logic        rx_inc,
   output logic        enable,
   output logic [31:0] if_v4,
   output logic [47:0] if_mac,
   output logic [31:0] dest_v4,
   output logic [47:0] dest_mac,
   output logic [31:0] rd_word_c
);

   logic [CNT_W-1:0] tx_cnt;
   logic [CNT_W-1:0] rx_cnt;
   logic [31:0]      if_mac_lo_w;
   logic [31:0]      dest_mac_lo_w;
   logic             ctrl_clr;
   logic             tx_clr;
   logic             rx_clr;

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic clr);
      if (clr) return inc ? CNT_W'(1) : '0;
      if (inc && (cnt != '1)) return cnt + CNT_W'(1);
      return cnt;
   endfunction

   assign if_mac_lo_w   = merge_be({if_mac[15:0], 16'h0}, wr.data, wr.be);
   assign dest_mac_lo_w = merge_be({dest_mac[15:0], 16'h0}, wr.data, wr.be);
   assign ctrl_clr      = wr_apply && (wr.off == OFF_CTRL) && wr.be[3] && wr.data[1];
   assign tx_clr        = ctrl_clr || (rd_sel && (rd_off == OFF_TX_CNT));
   assign rx_clr        = ctrl_clr || (rd_sel && (rd_off == OFF_RX_CNT));

   // Configuration registers, written from the top's staging register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enable   <= 1'b1;
         if_v4    <= rst_if_v4(CH_IDX);
         if_mac   <= rst_if_mac(CH_IDX);
         dest_v4  <= RST_DEST_V4;
         dest_mac <= RST_DEST_MAC;
      end else if (wr_apply) begin
         case (wr.off)
            OFF_IF_V4:       if_v4          <= merge_be(if_v4, wr.data, wr.be);
            OFF_IF_MAC_HI:   if_mac[47:16]  <= merge_be(if_mac[47:16], wr.data, wr.be);
            OFF_IF_MAC_LO:   if_mac[15:0]   <= if_mac_lo_w[31:16];
            OFF_DEST_V4:     dest_v4        <= merge_be(dest_v4, wr.data, wr.be);
            OFF_DEST_MAC_HI: dest_mac[47:16] <= merge_be(dest_mac[47:16], wr.data, wr.be);
            OFF_DEST_MAC_LO: dest_mac[15:0] <= dest_mac_lo_w[31:16];
            OFF_CTRL:        if (wr.be[3]) enable <= wr.data[0];
            default: ;
         endcase
      end
   end

   // Counters see the enable value in force before any same-cycle ctrl write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_cnt <= '0;
         rx_cnt <= '0;
      end else begin
         tx_cnt <= cnt_next(tx_cnt, tx_inc && enable, tx_clr);
         rx_cnt <= cnt_next(rx_cnt, rx_inc && enable, rx_clr);
      end
   end

   always_comb begin
      rd_word_c = '0;
      case (rd_off)
         OFF_IF_V4:       rd_word_c = if_v4;
         OFF_IF_MAC_HI:   rd_word_c = if_mac[47:16];
         OFF_IF_MAC_LO:   rd_word_c = {if_mac[15:0], 16'h0};
         OFF_DEST_V4:     rd_word_c = dest_v4;
         OFF_DEST_MAC_HI: rd_word_c = dest_mac[47:16];
         OFF_DEST_MAC_LO: rd_word_c = {dest_mac[15:0], 16'h0};
         OFF_CTRL:        rd_word_c = {31'h0, enable};
         OFF_TX_CNT:      rd_word_c = 32'(tx_cnt);
         OFF_RX_CNT:      rd_word_c = 32'(rx_cnt);
         default: ;
      endcase
   end

endmodule

// File: rtl/pio_ep_regbank.sv
// PCIe PIO BAR0 register bank for NUM_CH tunnels: decode, 1-cycle read pipe, staged writes.
// Define PIO_REGBANK_ROM_EN to map the biosrom into region 11.
module pio_ep_regbank
   import pio_regbank_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned CNT_W  = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rd_req,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [3:0]          rd_be,
   output logic [31:0]         rd_data,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [3:0]          wr_be,
   input  logic [31:0]         wr_data,
   output logic                wr_busy,
   input  logic [NUM_CH-1:0]   tx_pkt_inc,
   input  logic [NUM_CH-1:0]   rx_pkt_inc,
   output logic [NUM_CH-1:0]   ch_enable,
   output logic [NUM_CH*32-1:0] ch_if_v4addr,
   output logic [NUM_CH*48-1:0] ch_if_macaddr,
   output logic [NUM_CH*32-1:0] ch_dest_v4addr,
   output logic [NUM_CH*48-1:0] ch_dest_macaddr
);

   localparam int unsigned CH_W = 5;

   logic [1:0]        rd_region;
   logic [CH_W-1:0]   rd_ch;
   logic [3:0]        rd_off;
   logic              rd_ch_ok;
   logic [31:0]       rd_mux;

   logic [ADDR_W-1:0] stg_addr;
   logic [3:0]        stg_be;
   logic [31:0]       stg_data;
   logic [CH_W-1:0]   stg_ch;
   logic              wr_hit;
   ch_wr_t            ch_wr;

   logic [31:0]       ch_word [NUM_CH];
   logic              unused_bits;

   assign rd_region = rd_addr[13:12];
   assign rd_ch     = rd_addr[8:4];
   assign rd_off    = rd_addr[3:0];
   assign rd_ch_ok  = {1'b0, rd_ch} < 6'(NUM_CH);

   assign stg_ch    = stg_addr[8:4];
   assign wr_hit    = wr_busy && (stg_addr[13:12] == REG_CH);
   assign ch_wr     = '{off: stg_addr[3:0], be: stg_be, data: stg_data};

   assign unused_bits = ^{rd_be, rd_addr, stg_addr};

   // Write staging: one accepted write occupies exactly the following cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_busy  <= 1'b0;
         stg_addr <= '0;
         stg_be   <= '0;
         stg_data <= '0;
      end else if (wr_en && !wr_busy) begin
         wr_busy  <= 1'b1;
         stg_addr <= wr_addr;
         stg_be   <= wr_be;
         stg_data <= wr_data;
      end else begin
         wr_busy  <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pio_regbank_ch #(
         .CH_IDX (i),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_apply  (wr_hit && (stg_ch == CH_W'(i))),
         .wr        (ch_wr),
         .rd_off    (rd_off),
         .rd_sel    (rd_req && (rd_region == REG_CH) && (rd_ch == CH_W'(i))),
         .tx_inc    (tx_pkt_inc[i]),
         .rx_inc    (rx_pkt_inc[i]),
         .enable    (ch_enable[i]),
         .if_v4     (ch_if_v4addr[32*i +: 32]),
         .if_mac    (ch_if_macaddr[48*i +: 48]),
         .dest_v4   (ch_dest_v4addr[32*i +: 32]),
         .dest_mac  (ch_dest_macaddr[48*i +: 48]),
         .rd_word_c (ch_word[i])
      );
   end

`ifdef PIO_REGBANK_ROM_EN
   logic [31:0] rom_data;

   // biosrom returns its word combinationally; the read pipe adds the single cycle
   biosrom u_biosrom (
      .addr (rd_addr[11:0]),
      .data (rom_data)
   );
`endif

   always_comb begin
      rd_mux = '0;
      case (rd_region)
         REG_CH: begin
            if (rd_ch_ok && (rd_off == OFF_ID)) begin
               rd_mux = {ID_HI, 16'(NUM_CH)};
            end else begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (rd_ch == CH_W'(i)) rd_mux = ch_word[i];
               end
            end
         end
`ifdef PIO_REGBANK_ROM_EN
         REG_ROM: rd_mux = rom_data;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pio_ep_regbank.sv
// Bench for pio_ep_regbank: directed cases plus randomized traffic against a behavioural model.
module tb_pio_ep_regbank;

   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  rd_req = 1'b0;
   logic [ADDR_W-1:0]     rd_addr = '0;
   logic [3:0]            rd_be = 4'hF;
   logic [31:0]           rd_data;
   logic                  rd_valid;
   logic                  wr_en = 1'b0;
   logic [ADDR_W-1:0]     wr_addr = '0;
   logic [3:0]            wr_be = '0;
   logic [31:0]           wr_data = '0;
   logic                  wr_busy;
   logic [NUM_CH-1:0]     tx_pkt_inc = '0;
   logic [NUM_CH-1:0]     rx_pkt_inc = '0;
   logic [NUM_CH-1:0]     ch_enable;
   logic [NUM_CH*32-1:0]  ch_if_v4addr;
   logic [NUM_CH*48-1:0]  ch_if_macaddr;
   logic [NUM_CH*32-1:0]  ch_dest_v4addr;
   logic [NUM_CH*48-1:0]  ch_dest_macaddr;

   always #5 clk = ~clk;

   pio_ep_regbank #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rd_req          (rd_req),
      .rd_addr         (rd_addr),
      .rd_be           (rd_be),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_be           (wr_be),
      .wr_data         (wr_data),
      .wr_busy         (wr_busy),
      .tx_pkt_inc      (tx_pkt_inc),
      .rx_pkt_inc      (rx_pkt_inc),
      .ch_enable       (ch_enable),
      .ch_if_v4addr    (ch_if_v4addr),
      .ch_if_macaddr   (ch_if_macaddr),
      .ch_dest_v4addr  (ch_dest_v4addr),
      .ch_dest_macaddr (ch_dest_macaddr)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       data;
   } wr_t;

   logic [31:0]  m_if_v4   [NUM_CH];
   logic [47:0]  m_if_mac  [NUM_CH];
   logic [31:0]  m_dest_v4 [NUM_CH];
   logic [47:0]  m_dest_mac[NUM_CH];
   bit           m_en      [NUM_CH];
   int unsigned  m_tx      [NUM_CH];
   int unsigned  m_rx      [NUM_CH];
   logic [31:0]  m_rd_data;
   logic         m_rd_valid;
   wr_t          m_pend[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = cur;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) r[(3-k)*8 +: 8] = d[(3-k)*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
      int ch = int'(a[8:4]);
      int off = int'(a[3:0]);
      if (a[13:12] != 2'b01 || ch >= NUM_CH) return 32'h0;
      case (off)
         0:  return m_if_v4[ch];
         2:  return m_if_mac[ch][47:16];
         3:  return {m_if_mac[ch][15:0], 16'h0};
         4:  return m_dest_v4[ch];
         6:  return m_dest_mac[ch][47:16];
         7:  return {m_dest_mac[ch][15:0], 16'h0};
         8:  return {31'h0, m_en[ch]};
         9:  return m_tx[ch];
         10: return m_rx[ch];
         15: return 32'h5049_0000 | NUM_CH;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_if_v4[i]    = {24'h0A0015, 8'((199 + i) % 256)};
         m_if_mac[i]   = 48'h003776_000001 + 48'(i);
         m_dest_v4[i]  = 32'h0A0015FF;
         m_dest_mac[i] = '1;
         m_en[i]       = 1'b1;
         m_tx[i]       = 0;
         m_rx[i]       = 0;
      end
      m_pend.delete();
      m_rd_data  = 32'h0;
      m_rd_valid = 1'b0;
   endtask

   // Everything the clock edge does, from the inputs present just before it
   task automatic model_step();
      bit   clr_tx [NUM_CH];
      bit   clr_rx [NUM_CH];
      bit   apply;
      wr_t  w;
      int   ch, off, wch, woff;
      logic [31:0] t;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         clr_tx[i] = 0;
         clr_rx[i] = 0;
      end
      m_rd_valid = rd_req;
      if (rd_req) begin
         m_rd_data = model_read(rd_addr);
         ch  = int'(rd_addr[8:4]);
         off = int'(rd_addr[3:0]);
         if (rd_addr[13:12] == 2'b01 && ch < NUM_CH) begin
            if (off == 9)  clr_tx[ch] = 1;
            if (off == 10) clr_rx[ch] = 1;
         end
      end
      apply = 0;
      if (m_pend.size() != 0) begin
         w = m_pend.pop_front();
         apply = 1;
      end else if (wr_en) begin
         m_pend.push_back('{addr: wr_addr, be: wr_be, data: wr_data});
      end
      wch  = apply ? int'(w.addr[8:4]) : 0;
      woff = apply ? int'(w.addr[3:0]) : 0;
      if (apply && (w.addr[13:12] != 2'b01 || wch >= NUM_CH)) apply = 0;
      if (apply && woff == 8 && w.be[3] && w.data[1]) begin
         clr_tx[wch] = 1;
         clr_rx[wch] = 1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (clr_tx[i]) m_tx[i] = (tx_pkt_inc[i] && m_en[i]) ? 1 : 0;
         else if (tx_pkt_inc[i] && m_en[i] && m_tx[i] < CNT_MAX) m_tx[i]++;
         if (clr_rx[i]) m_rx[i] = (rx_pkt_inc[i] && m_en[i]) ? 1 : 0;
         else if (rx_pkt_inc[i] && m_en[i] && m_rx[i] < CNT_MAX) m_rx[i]++;
      end
      if (apply) begin
         case (woff)
            0: m_if_v4[wch] = lanes(m_if_v4[wch], w.data, w.be);
            2: m_if_mac[wch][47:16] = lanes(m_if_mac[wch][47:16], w.data, w.be);
            3: begin
               t = lanes({m_if_mac[wch][15:0], 16'h0}, w.data, w.be);
               m_if_mac[wch][15:0] = t[31:16];
            end
            4: m_dest_v4[wch] = lanes(m_dest_v4[wch], w.data, w.be);
            6: m_dest_mac[wch][47:16] = lanes(m_dest_mac[wch][47:16], w.data, w.be);
            7: begin
               t = lanes({m_dest_mac[wch][15:0], 16'h0}, w.data, w.be);
               m_dest_mac[wch][15:0] = t[31:16];
            end
            8: if (w.be[3]) m_en[wch] = w.data[0];
            default: ;
         endcase
      end
   endtask

   task automatic compare();
      chk("rd_valid", rd_valid, m_rd_valid);
      chk("rd_data", rd_data, m_rd_data);
      chk("wr_busy", wr_busy, m_pend.size() != 0);
      for (int i = 0; i < NUM_CH; i++) begin
         chk("ch_enable", ch_enable[i], m_en[i]);
         chk("ch_if_v4addr", ch_if_v4addr[32*i +: 32], m_if_v4[i]);
         chk("ch_if_macaddr", ch_if_macaddr[48*i +: 48], m_if_mac[i]);
         chk("ch_dest_v4addr", ch_dest_v4addr[32*i +: 32], m_dest_v4[i]);
         chk("ch_dest_macaddr", ch_dest_macaddr[48*i +: 48], m_dest_mac[i]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      rd_req  = 1'b1;
      rd_addr = a;
      cycle();
      rd_req  = 1'b0;
      d = rd_data;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      cycle();
      wr_en   = 1'b0;
      cycle();
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [1:0] region;
      region = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      return {region, 3'b000, 5'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
   endfunction

   logic [31:0] d;

   initial begin
      rst_n = 1'b0;
      cycle();
      cycle();
      chk("reset_rd_valid", rd_valid, 1'b0);
      chk("reset_wr_busy", wr_busy, 1'b0);
      rst_n = 1'b1;
      cycle();

      rd(14'h1000, d); chk("rst_if_v4_ch0", d, 32'h0A0015C7);
      rd(14'h1010, d); chk("rst_if_v4_ch1", d, 32'h0A0015C8);
      rd(14'h100F, d); chk("id_word", d, 32'h50490002);
      rd(14'h1012, d); chk("rst_if_mac_hi_ch1", d, 32'h00377600);
      rd(14'h1013, d); chk("rst_if_mac_lo_ch1", d, 32'h00020000);
      cycle();
      chk("rd_valid_idle", rd_valid, 1'b0);
      chk("rd_data_hold", rd_data, 32'h00020000);

      // byte-lane write, read during busy, dropped write while busy
      wr_en = 1'b1; wr_addr = 14'h1004; wr_be = 4'b0011; wr_data = 32'hC0A80001;
      cycle();
      chk("busy_after_wr", wr_busy, 1'b1);
      wr_data = 32'h11111111; wr_be = 4'hF; rd_req = 1'b1; rd_addr = 14'h1004;
      cycle();
      wr_en = 1'b0; rd_req = 1'b0;
      chk("rd_during_busy_old", rd_data, 32'h0A0015FF);
      chk("busy_dropped", wr_busy, 1'b0);
      rd(14'h1004, d); chk("rd_after_wr_new", d, 32'hC0A815FF);
      cycle();
      chk("second_wr_ignored", wr_busy, 1'b0);

      // tx counter, clear-on-read, coincident increment
      tx_pkt_inc = 2'b01;
      repeat (5) cycle();
      tx_pkt_inc = 2'b00;
      rd(14'h1009, d); chk("tx_cnt_5", d, 32'd5);
      rd(14'h1009, d); chk("tx_cnt_cleared", d, 32'd0);
      tx_pkt_inc = 2'b01;
      repeat (3) cycle();
      rd(14'h1009, d); chk("tx_cnt_coincident", d, 32'd3);
      tx_pkt_inc = 2'b00;
      rd(14'h1009, d); chk("tx_cnt_after_coincident", d, 32'd1);

      // saturation and disable
      rx_pkt_inc = 2'b01;
      repeat (20) cycle();
      rx_pkt_inc = 2'b00;
      rd(14'h100A, d); chk("rx_cnt_saturated", d, 32'h0000000F);
      wr(14'h1008, 32'h0, 4'hF);
      rx_pkt_inc = 2'b01;
      repeat (3) cycle();
      rx_pkt_inc = 2'b00;
      rd(14'h100A, d); chk("rx_cnt_disabled", d, 32'd0);
      rd(14'h1008, d); chk("ctrl_disabled", d, 32'd0);

      // ctrl bit1 clears counters and reads back as zero
      wr(14'h1018, 32'h1, 4'hF);
      tx_pkt_inc = 2'b10;
      repeat (4) cycle();
      tx_pkt_inc = 2'b00;
      wr(14'h1018, 32'h3, 4'hF);
      rd(14'h1019, d); chk("ctrl_clear_tx", d, 32'd0);
      rd(14'h1018, d); chk("ctrl_bit1_reads_0", d, 32'd1);
      wr(14'h1008, 32'h1, 4'hF);

      // out-of-range channel, zero and ROM regions
      rd(14'h1020, d); chk("ch2_reads_0", d, 32'd0);
      wr(14'h1020, 32'hFFFFFFFF, 4'hF);
      wr(14'h2000, 32'hFFFFFFFF, 4'hF);
      rd(14'h102F, d); chk("ch2_id_reads_0", d, 32'd0);
      rd(14'h3000, d); chk("rom_region_0", d, 32'd0);
      rd(14'h1005, d); chk("unused_off_0", d, 32'd0);

      // randomized traffic with one mid-run reset
      for (int i = 0; i < 4000; i++) begin
         rst_n      = (i != 2000);
         rd_req     = ($urandom_range(0, 1) == 0);
         rd_addr    = rand_addr();
         rd_be      = 4'($urandom);
         wr_en      = ($urandom_range(0, 2) == 0);
         wr_addr    = rand_addr();
         wr_be      = 4'($urandom);
         wr_data    = $urandom;
         tx_pkt_inc = NUM_CH'($urandom);
         rx_pkt_inc = NUM_CH'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
